// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/result bundle for the sequential multiplier: start + operands in, busy/done/product out.
// master = operand issuer / result consumer, slave = multiplier core.
interface seq_shift_add_multiplier_if #(
    parameter int N = 16
);
    logic             start;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Shift-add multiplier: N busy cycles per result, one-cycle done pulse, start ignored while busy.
// Define SIGNED_MULT_EN for two's-complement operands via radix-2 Booth recoding.
module seq_shift_add_multiplier #(
    parameter int N = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    seq_shift_add_multiplier_if.slave  bus
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_busy;
    logic             w_done;
    logic             w_last;

    // Accumulator carries one guard bit so the Booth path cannot overflow on the most negative operand.
    logic [N:0]       r_a;
    logic [N-1:0]     r_q;
    logic [N-1:0]     r_m;
    logic [CW-1:0]    r_count;
    logic [2*N-1:0]   r_product;

    logic [N+1:0]     w_sum;
    logic [N:0]       w_a_nxt;
    logic [N-1:0]     w_q_nxt;

`ifdef SIGNED_MULT_EN
    logic             r_q_m1;

    always_comb begin
        w_sum = {r_a[N], r_a};
        case ({r_q[0], r_q_m1})
            2'b10:   w_sum = {r_a[N], r_a} - {{2{r_m[N-1]}}, r_m};
            2'b01:   w_sum = {r_a[N], r_a} + {{2{r_m[N-1]}}, r_m};
            default: w_sum = {r_a[N], r_a};
        endcase
    end
`else
    always_comb begin
        w_sum = {1'b0, r_a};
        if (r_q[0]) begin
            w_sum = {1'b0, r_a} + {2'b00, r_m};
        end
    end
`endif

    // Shifting the full-width sum gives a logical shift when unsigned and an arithmetic one under Booth.
    assign w_a_nxt = w_sum[N+1:1];
    assign w_q_nxt = {w_sum[0], r_q[N-1:1]};
    assign w_last  = (r_count == CW'(N - 1));

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_a       <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_count   <= '0;
            r_product <= '0;
`ifdef SIGNED_MULT_EN
            r_q_m1    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a       <= '0;
            r_q       <= bus.multiplier;
            r_m       <= bus.multiplicand;
            r_count   <= '0;
`ifdef SIGNED_MULT_EN
            r_q_m1    <= 1'b0;
`endif
        end else if (r_state == S_RUN) begin
            r_a       <= w_a_nxt;
            r_q       <= w_q_nxt;
            r_count   <= r_count + CW'(1);
`ifdef SIGNED_MULT_EN
            r_q_m1    <= r_q[0];
`endif
            if (w_last) begin
                r_product <= {w_a_nxt[N-1:0], w_q_nxt};
            end
        end
    end

    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.product = r_product;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier (N=16) against an arithmetic reference model.
module tb_seq_shift_add_multiplier;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    seq_shift_add_multiplier_if #(.N(N)) bus();

    seq_shift_add_multiplier #(.N(N)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        longint p;
`ifdef SIGNED_MULT_EN
        p = longint'($signed(a)) * longint'($signed(b));
`else
        p = longint'(a) * longint'(b);
`endif
        return p[2*N-1:0];
    endfunction

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        @(negedge clk);
        bus.start        = 1'b0;
        bus.multiplicand = N'($urandom);
        bus.multiplier   = N'($urandom);
    endtask

    task automatic wait_done(output int busy_cycles, output bit seen);
        busy_cycles = 0;
        seen        = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        n_tests++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
        n_tests++;
        if (bus.product !== 32'h0) begin n_fail++; $display("FAIL reset_product got=%h exp=0", bus.product); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        bit seen;
        issue(16'd3, 16'd5);
        wait_done(cyc, seen);
        n_tests++;
        if (seen !== 1'b1 || cyc != N) begin
            n_fail++; $display("FAIL basic_latency seen=%0b busy_cycles=%0d exp=%0d", seen, cyc, N);
        end
        n_tests++;
        if (bus.product !== 32'h0000000F) begin n_fail++; $display("FAIL basic_product got=%h exp=0000000f", bus.product); end
        @(negedge clk);
        n_tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_done_pulse done=%0b busy=%0b exp 0/0", bus.done, bus.busy);
        end
        n_tests++;
        if (bus.product !== 32'h0000000F) begin n_fail++; $display("FAIL basic_hold got=%h exp=0000000f", bus.product); end
    endtask

    task automatic test_corners();
        logic [N-1:0] ta [6] = '{16'hFFFF, 16'h0000, 16'h8000, 16'hFFFD, 16'h7FFF, 16'hFFFF};
        logic [N-1:0] tb [6] = '{16'hFFFF, 16'h1234, 16'h8000, 16'h0005, 16'h8000, 16'h0001};
        logic [2*N-1:0] exp;
        int cyc;
        bit seen;
        for (int i = 0; i < 6; i++) begin
            exp = ref_mul(ta[i], tb[i]);
            issue(ta[i], tb[i]);
            wait_done(cyc, seen);
            n_tests++;
            if (seen !== 1'b1 || cyc != N) begin
                n_fail++; $display("FAIL corner%0d_latency seen=%0b busy_cycles=%0d exp=%0d", i, seen, cyc, N);
            end
            n_tests++;
            if (bus.product !== exp) begin
                n_fail++; $display("FAIL corner%0d_product %h*%h got=%h exp=%h", i, ta[i], tb[i], bus.product, exp);
            end
`ifdef SIGNED_MULT_EN
            if (i == 2) begin
                n_tests++;
                if (bus.product !== 32'h40000000) begin n_fail++; $display("FAIL corner_minneg got=%h exp=40000000", bus.product); end
            end
`else
            if (i == 0) begin
                n_tests++;
                if (bus.product !== 32'hFFFE0001) begin n_fail++; $display("FAIL corner_max got=%h exp=fffe0001", bus.product); end
            end
`endif
        end
    endtask

    task automatic test_random();
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2*N-1:0] exp;
        int cyc;
        bit seen;
        for (int i = 0; i < 25; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            exp = ref_mul(a, b);
            issue(a, b);
            wait_done(cyc, seen);
            n_tests++;
            if (seen !== 1'b1 || bus.product !== exp) begin
                n_fail++; $display("FAIL random%0d %h*%h seen=%0b got=%h exp=%h", i, a, b, seen, bus.product, exp);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2*N-1:0] exp;
        logic [2*N-1:0] got;
        int n_done;
        a = N'($urandom);
        b = N'($urandom);
        exp = ref_mul(a, b);
        got = '0;
        n_done = 0;
        issue(a, b);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 16'd7;
        bus.multiplier = 16'd7;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                n_done++;
                if (n_done == 1) got = bus.product;
            end
            @(negedge clk);
        end
        n_tests++;
        if (n_done != 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d exp=1", n_done); end
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL ignore_product got=%h exp=%h", got, exp); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2*N-1:0] exp1;
        logic [2*N-1:0] mid;
        int cyc;
        int gap;
        bit seen;
        a = N'($urandom);
        b = N'($urandom);
        exp1 = ref_mul(a, b);
        mid = '0;
        issue(a, b);
        wait_done(cyc, seen);
        n_tests++;
        if (seen !== 1'b1 || bus.product !== exp1) begin
            n_fail++; $display("FAIL b2b_first seen=%0b got=%h exp=%h", seen, bus.product, exp1);
        end
        bus.start = 1'b1;
        bus.multiplicand = 16'd2;
        bus.multiplier = 16'd9;
        gap = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
            gap++;
            if (i == 8) mid = bus.product;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (seen !== 1'b1 || gap != N + 1) begin
            n_fail++; $display("FAIL b2b_gap seen=%0b got=%0d exp=%0d", seen, gap, N + 1);
        end
        n_tests++;
        if (mid !== exp1) begin n_fail++; $display("FAIL b2b_hold_during_run got=%h exp=%h", mid, exp1); end
        n_tests++;
        if (bus.product !== 32'h00000012) begin n_fail++; $display("FAIL b2b_second got=%h exp=00000012", bus.product); end
    endtask

    task automatic test_reset_mid_run();
        int n_done;
        int cyc;
        bit seen;
        logic [2*N-1:0] exp;
        issue(N'($urandom), N'($urandom));
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL midreset_flags busy=%0b done=%0b exp 0/0", bus.busy, bus.done);
        end
        n_tests++;
        if (bus.product !== 32'h0) begin n_fail++; $display("FAIL midreset_product got=%h exp=0", bus.product); end
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) n_done++;
        end
        n_tests++;
        if (n_done != 0) begin n_fail++; $display("FAIL midreset_aborted_activity got=%0d exp=0", n_done); end
        exp = ref_mul(16'd100, 16'd200);
        issue(16'd100, 16'd200);
        wait_done(cyc, seen);
        n_tests++;
        if (seen !== 1'b1 || cyc != N || bus.product !== exp) begin
            n_fail++; $display("FAIL midreset_restart seen=%0b cycles=%0d got=%h exp=%h", seen, cyc, bus.product, exp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
